// File: rtl/wb_memtest_master.sv
// Wishbone classic initiator: fills a word window with a Galois LFSR pattern,
// reads it back and reports mismatches, first failing address and timeouts.
module wb_memtest_master #(
    parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
    parameter int unsigned WORDS     = 256,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        active,
    input  logic        start,
    input  logic [31:0] seed,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [31:0] fail_addr,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WR_GAP, S_RD_INIT, S_RD, S_RD_GAP, S_DONE
    } state_t;

    localparam logic [15:0] LP_WORDS    = 16'(WORDS);
    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT - 1);

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_seed;
    logic [31:0] r_lfsr;
    logic [15:0] r_index;
    logic [15:0] r_tmo_cnt;
    logic [15:0] r_err_count;
    logic [31:0] r_fail_addr;
    logic        r_pass;
    logic        r_timeout;

    logic        w_start_ok;
    logic        w_req;
    logic        w_ack;
    logic        w_tmo;
    logic        w_last;
    logic        w_mismatch;
    logic [31:0] w_addr;
    logic [31:0] w_seed_nz;

    assign w_start_ok = active & start & (r_state == S_IDLE || r_state == S_DONE);
    // Requests are gated by active combinationally so the bus drops the same cycle
    assign w_req      = active & (r_state == S_WR || r_state == S_RD);
    assign w_ack      = w_req & wbm_ack_i;
    assign w_tmo      = w_req & ~wbm_ack_i & (r_tmo_cnt == LP_TMO_LAST);
    assign w_last     = (r_index == LP_WORDS);
    assign w_mismatch = (r_state == S_RD) & w_ack & (wbm_dat_i != r_lfsr);
    assign w_addr     = ADDR_BASE + {14'd0, r_index, 2'b00};
    assign w_seed_nz  = (seed == 32'd0) ? 32'd1 : seed;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!active && r_state != S_IDLE) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (w_start_ok) w_next = S_WR;
                S_WR:           if (w_ack) w_next = S_WR_GAP; else if (w_tmo) w_next = S_DONE;
                S_WR_GAP:       w_next = w_last ? S_RD_INIT : S_WR;
                S_RD_INIT:      w_next = S_RD;
                S_RD:           if (w_ack) w_next = S_RD_GAP; else if (w_tmo) w_next = S_DONE;
                S_RD_GAP:       w_next = w_last ? S_DONE : S_RD;
                default:        w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = ~(r_state == S_IDLE || r_state == S_DONE);
        done      = (r_state == S_DONE);
        wbm_cyc_o = w_req;
        wbm_stb_o = w_req;
        wbm_we_o  = w_req & (r_state == S_WR);
        wbm_sel_o = w_req ? 4'hF : 4'h0;
        wbm_adr_o = w_req ? w_addr : 32'd0;
        wbm_dat_o = (w_req && r_state == S_WR) ? r_lfsr : 32'd0;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_seed      <= 32'd0;
            r_lfsr      <= 32'd0;
            r_index     <= 16'd0;
            r_tmo_cnt   <= 16'd0;
            r_err_count <= 16'd0;
            r_fail_addr <= 32'd0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else if (w_start_ok) begin
            r_seed      <= w_seed_nz;
            r_lfsr      <= w_seed_nz;
            r_index     <= 16'd0;
            r_tmo_cnt   <= 16'd0;
            r_err_count <= 16'd0;
            r_fail_addr <= 32'd0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            // Counter restarts whenever the strobe is not held waiting
            r_tmo_cnt <= (w_req && !wbm_ack_i) ? r_tmo_cnt + 16'd1 : 16'd0;
            if (w_ack) begin
                r_lfsr  <= lfsr_step(r_lfsr);
                r_index <= r_index + 16'd1;
            end
            if (w_mismatch) begin
                if (r_err_count == 16'd0)    r_fail_addr <= w_addr;
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end
            if (r_state == S_RD_INIT) begin
                r_lfsr  <= r_seed;
                r_index <= 16'd0;
            end
            if (w_tmo) r_timeout <= 1'b1;
            if (active && r_state == S_RD_GAP && w_last)
                r_pass <= (r_err_count == 16'd0) && !r_timeout;
        end
    end

    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign err_count = r_err_count;
    assign fail_addr = r_fail_addr;

endmodule

// File: tb/tb_wb_memtest_master.sv
// Bench for wb_memtest_master: wait-state RAM slave with optional read
// corruption, access log, and a pattern/status model derived from the LFSR rule.
module tb_wb_memtest_master;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam int          WORDS   = 4;
    localparam int          TIMEOUT = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        active = 1'b0;
    logic        start = 1'b0;
    logic [31:0] seed = 32'd0;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] fail_addr;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic        wbm_ack_i;

    wb_memtest_master #(.ADDR_BASE(BASE), .WORDS(WORDS), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .active(active), .start(start),
        .seed(seed), .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .err_count(err_count), .fail_addr(fail_addr), .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
        .wbm_ack_i(wbm_ack_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Slave model
    logic [31:0] mem [0:WORDS-1];
    logic        no_ack = 1'b0;
    logic        corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = 32'd0;
    logic [31:0] corrupt_mask = 32'd0;
    int          max_wait = 0;
    int          wait_n = 0;
    int          wcnt = 0;
    logic [31:0] w_off;
    logic [31:0] rd_word;

    logic        log_we [$];
    logic [31:0] log_adr [$];
    logic [31:0] log_dat [$];

    assign w_off     = wbm_adr_o - BASE;
    assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & ~no_ack & (wcnt >= wait_n);

    always_comb begin
        rd_word = 32'hDEAD_BEEF;
        if (w_off[31:4] == 28'd0) rd_word = mem[w_off[3:2]];
        if (corrupt_en && wbm_adr_o == corrupt_addr) rd_word = rd_word ^ corrupt_mask;
    end
    assign wbm_dat_i = rd_word;

    always @(posedge wb_clk_i) begin
        if (wbm_ack_i) begin
            wcnt   <= 0;
            wait_n <= $urandom_range(0, max_wait);
            if (wbm_we_o && w_off[31:4] == 28'd0) mem[w_off[3:2]] <= wbm_dat_o;
            log_we.push_back(wbm_we_o);
            log_adr.push_back(wbm_adr_o);
            log_dat.push_back(wbm_we_o ? wbm_dat_o : wbm_dat_i);
        end else if (wbm_cyc_o && wbm_stb_o) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] s);
        logic [31:0] h;
        h = s / 2;
        if (s % 2 == 1) h = h ^ 32'h8020_0003;
        return h;
    endfunction

    task automatic clear_log();
        log_we.delete();
        log_adr.delete();
        log_dat.delete();
    endtask

    // Full-sweep expectation: WORDS writes of the pattern then WORDS reads, in order
    task automatic check_log(input logic [31:0] sd);
        logic [31:0] s;
        s = (sd == 32'd0) ? 32'd1 : sd;
        check_eq("log_len", 32'(log_adr.size()), 32'(2 * WORDS));
        if (log_adr.size() == 2 * WORDS) begin
            for (int i = 0; i < WORDS; i++) begin
                check_eq("wr_we", {31'd0, log_we[i]}, 32'd1);
                check_eq("wr_adr", log_adr[i], BASE + 32'(4 * i));
                check_eq("wr_dat", log_dat[i], s);
                s = ref_next(s);
            end
            for (int i = 0; i < WORDS; i++) begin
                check_eq("rd_we", {31'd0, log_we[WORDS + i]}, 32'd0);
                check_eq("rd_adr", log_adr[WORDS + i], BASE + 32'(4 * i));
            end
        end
    endtask

    task automatic run_sweep(input logic [31:0] sd, input int dup_at, output int ncyc);
        clear_log();
        @(negedge wb_clk_i);
        seed  = sd;
        start = 1'b1;
        @(posedge wb_clk_i);
        #1 start = 1'b0;
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
        ncyc = 0;
        while (!done && ncyc < 2000) begin
            if (ncyc == dup_at) begin
                start = 1'b1;
                seed  = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge wb_clk_i);
            #1;
            ncyc++;
        end
        start = 1'b0;
        if (!done) check_eq("done_reached", 32'd0, 32'd1);
    endtask

    task automatic check_status(input string tag, input logic exp_pass, input logic [15:0] exp_err,
                                input logic [31:0] exp_fail);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_pass"}, {31'd0, pass}, {31'd0, exp_pass});
        check_eq({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
        check_eq({tag, "_err"}, {16'd0, err_count}, {16'd0, exp_err});
        check_eq({tag, "_fail_addr"}, fail_addr, exp_fail);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ncyc;
        int          g;
        int          cw;
        logic [31:0] sd;
        logic [31:0] known [0:3];
        known[0] = 32'h0000_0001;
        known[1] = 32'h8020_0003;
        known[2] = 32'hC030_0002;
        known[3] = 32'h6018_0001;

        // Reset state
        #12;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check_eq("rst_adr", wbm_adr_o, 32'd0);
        check_eq("rst_sel", {28'd0, wbm_sel_o}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        active    = 1'b1;

        // Directed zero-wait sweep, seed 1
        run_sweep(32'd1, -1, ncyc);
        check_eq("zw_cycles", 32'(ncyc), 32'd17);
        check_log(32'd1);
        for (int i = 0; i < 4; i++)
            if (log_dat.size() > i) check_eq("known_pattern", log_dat[i], known[i]);
        check_status("zw", 1'b1, 16'd0, 32'd0);

        // Same sweep with bit 0 of word 2 flipped on read
        corrupt_en   = 1'b1;
        corrupt_addr = 32'h3000_0008;
        corrupt_mask = 32'h0000_0001;
        run_sweep(32'd1, -1, ncyc);
        check_log(32'd1);
        check_status("corrupt", 1'b0, 16'd1, 32'h3000_0008);
        corrupt_en = 1'b0;

        // Slave never acknowledges
        no_ack = 1'b1;
        clear_log();
        @(negedge wb_clk_i);
        seed  = 32'h1234_5678;
        start = 1'b1;
        @(posedge wb_clk_i);
        #1 start = 1'b0;
        g = 0;
        while (wbm_stb_o && g < 100) begin
            g++;
            @(posedge wb_clk_i);
            #1;
        end
        check_eq("tmo_stb_cycles", 32'(g), 32'(TIMEOUT));
        check_eq("tmo_done", {31'd0, done}, 32'd1);
        check_eq("tmo_flag", {31'd0, timeout}, 32'd1);
        check_eq("tmo_pass", {31'd0, pass}, 32'd0);
        check_eq("tmo_busy", {31'd0, busy}, 32'd0);
        check_eq("tmo_no_acks", 32'(log_adr.size()), 32'd0);
        no_ack = 1'b0;

        // Seed 0 replaced by 1; a start while busy is ignored
        run_sweep(32'd0, 3, ncyc);
        check_eq("seed0_cycles", 32'(ncyc), 32'd17);
        check_log(32'd0);
        check_status("seed0", 1'b1, 16'd0, 32'd0);

        // active dropped during the read phase
        clear_log();
        @(negedge wb_clk_i);
        seed  = 32'hCAFE_0001;
        start = 1'b1;
        @(posedge wb_clk_i);
        #1 start = 1'b0;
        g = 0;
        while (!(wbm_cyc_o && !wbm_we_o) && g < 100) begin
            g++;
            @(posedge wb_clk_i);
            #1;
        end
        check_eq("abort_reached_read", {31'd0, wbm_cyc_o & ~wbm_we_o}, 32'd1);
        active = 1'b0;
        #1;
        check_eq("abort_cyc_same_cycle", {31'd0, wbm_cyc_o}, 32'd0);
        check_eq("abort_stb_same_cycle", {31'd0, wbm_stb_o}, 32'd0);
        @(posedge wb_clk_i);
        #1;
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        active = 1'b1;
        run_sweep(32'hCAFE_0001, -1, ncyc);
        check_log(32'hCAFE_0001);
        check_status("restart", 1'b1, 16'd0, 32'd0);

        // Asynchronous reset in the middle of a write
        @(negedge wb_clk_i);
        seed  = 32'h0BAD_F00D;
        start = 1'b1;
        @(posedge wb_clk_i);
        #1 start = 1'b0;
        g = 0;
        while (!(wbm_cyc_o && wbm_we_o) && g < 100) begin
            g++;
            @(posedge wb_clk_i);
            #1;
        end
        #2 wb_rst_ni = 1'b0;
        #1;
        check_eq("arst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check_eq("arst_stb_we", {30'd0, wbm_stb_o, wbm_we_o}, 32'd0);
        check_eq("arst_adr", wbm_adr_o, 32'd0);
        check_eq("arst_dat", wbm_dat_o, 32'd0);
        check_eq("arst_status", {28'd0, busy, done, pass, timeout}, 32'd0);
        check_eq("arst_err_fail", {16'd0, err_count} | fail_addr, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;

        // Randomized sweeps: random seeds, wait states and single-word corruption
        for (int r = 0; r < 12; r++) begin
            sd       = (r == 0) ? 32'd0 : $urandom;
            max_wait = $urandom_range(0, TIMEOUT - 3);
            cw       = $urandom_range(0, WORDS);
            corrupt_en   = (cw < WORDS);
            corrupt_addr = BASE + 32'(4 * cw);
            corrupt_mask = $urandom;
            if (corrupt_mask == 32'd0) corrupt_mask = 32'd1;
            run_sweep(sd, -1, ncyc);
            check_log(sd);
            if (cw < WORDS) check_status("rand", 1'b0, 16'd1, BASE + 32'(4 * cw));
            else            check_status("rand", 1'b1, 16'd0, 32'd0);
        end
        corrupt_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_memtest_master.md
Name: wb_memtest_master

Overview:
Wishbone classic initiator that runs a self-contained write-then-read-verify sweep over a word-addressed memory window. It fills the window with an LFSR-generated pattern, reads it back and compares. It targets the Wishbone-to-OpenRAM responder in the user project area, but works against any Wishbone classic slave. Results (pass/fail, error count, first failing address, timeout) are exposed on status ports for the logic analyser.

Parameters:
ADDR_BASE, 32'h3000_0000, byte address of word 0 of the tested window
WORDS, 256, number of 32-bit words swept (1..65535)
TIMEOUT, 255, maximum cycles to wait for wbm_ack_i per access (1..65535)

Ports:
wb_clk_i  input  1  clock
wb_rst_ni  input  1  asynchronous active-low reset
active  input  1  block enable; low forces idle
start  input  1  one-cycle pulse starts a sweep (ignored unless state IDLE or DONE)
seed  input  32  LFSR seed, sampled on start
busy  output  1  high from start until DONE
done  output  1  high in DONE, cleared by next accepted start
pass  output  1  valid when done: no mismatches and no timeout
timeout  output  1  valid when done: an access exceeded TIMEOUT
err_count  output  16  mismatch count, saturating at 16'hFFFF
fail_addr  output  32  byte address of first mismatch; 0 if none
wbm_cyc_o  output  1  Wishbone cycle
wbm_stb_o  output  1  Wishbone strobe
wbm_we_o  output  1  write enable
wbm_sel_o  output  4  byte selects, always 4'hF during strobe
wbm_adr_o  output  32  byte address
wbm_dat_o  output  32  write data
wbm_dat_i  input  32  read data
wbm_ack_i  input  1  acknowledge

Behaviour:
- Reset (wb_rst_ni low, async): state IDLE; all outputs 0; index, LFSR, counters cleared.
- LFSR: 32-bit Galois, right shift. next = lsb ? (s>>1) ^ 32'h8020_0003 : s>>1. A seed of 0 is replaced by 32'h0000_0001. Word i uses the LFSR value after i steps (word 0 = seed).
- States: IDLE -> WR -> WR_GAP -> (WR | RD_INIT) -> RD -> RD_GAP -> (RD | DONE); DONE -> WR on start.
- Accepted start (active=1, state IDLE/DONE): latch seed; clear done, pass, timeout, err_count, fail_addr, index; busy=1; enter WR on the next cycle.
- WR: cyc=stb=we=1, sel=F, adr=ADDR_BASE+4*index, dat_o=lfsr. Signals held stable until ack sampled high.
- On ack: go to WR_GAP, with cyc/stb/we low for exactly one cycle; step LFSR; index++. If index reaches WORDS: go to RD_INIT, which reloads the LFSR from the latched seed and clears index (1 cycle).
- RD: cyc=stb=1, we=0, same address rule. On ack, compare wbm_dat_i to lfsr in that same cycle.
  - On mismatch: err_count++ (saturating). If this is the first mismatch, fail_addr = current adr.
  - Then RD_GAP (1 idle cycle), step LFSR, index++. After WORDS reads, go to DONE.
- Minimum access time: 1 request cycle plus 1 gap cycle per word. Zero-wait slave: 2*WORDS cycles per phase.
- Timeout: a per-access counter resets when stb rises. If ack is not seen within TIMEOUT cycles of stb high, drop cyc/stb, set timeout=1, and go to DONE with pass=0.
- DONE: busy=0, done=1, pass=(err_count==0 && !timeout). Status held until the next accepted start.
- active low in any non-IDLE state: cyc/stb/we drop the same cycle (combinationally gated); next state is IDLE; busy=0; done=0; status retained.
- start while busy: ignored. An ack arriving outside WR/RD is ignored.
- index width: 16 bits, compared against WORDS, no wrap.

Test Plan:
- Zero-wait RAM model, seed=1, WORDS=4: writes to 0x3000_0000/04/08/0C carry data 0x00000001, 0x80200003, 0xC0300002, 0x60180001; reads match; done after 16+1 cycles; pass=1, err_count=0.
- Same run, but the model corrupts the read at 0x3000_0008 (bit 0 flipped) -> err_count=1, fail_addr=0x3000_0008, pass=0.
- Slave never acks, TIMEOUT=8 -> stb drops 8 cycles after rising on the first write; timeout=1, done=1, pass=0, busy=0.
- seed=0 -> first write data 0x00000001; second start during busy is ignored, and the address sequence is unchanged.
- active deasserted during a read phase -> cyc/stb low the same cycle, state IDLE, done=0; a new start with active=1 restarts from word 0.
- wb_rst_ni pulsed low mid-write, asynchronously -> all outputs 0 immediately; wbm_cyc_o is low before the next clock edge.
